// File: rtl/small_poly_unpack_if.sv
// -----------------------------------------------------------------------------
// small_poly_unpack_if
//
// Purpose : bundles the two data paths of the small-polynomial unpacker:
//           the packed byte stream coming from the input byte FIFO and the
//           coefficient write port going to the small-poly RAM.
//
// Signals :
//   in_byte   [7:0]  packed coefficient byte (4 x 2-bit codes, bits[1:0] first)
//   in_valid         in_byte is valid
//   in_ready         unpacker accepts the byte this cycle (in_valid && in_ready)
//   mem_we           coefficient write strobe
//   mem_addr  [10:0] coefficient index 0..676
//   mem_din   [10:0] coefficient value (11'h7FF / 11'h000 / 11'h001)
//
// Modports:
//   slave  - the unpacker: consumes bytes, drives the RAM write port
//   master - the environment: supplies bytes, observes the RAM write port
// -----------------------------------------------------------------------------
interface small_poly_unpack_if;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [10:0] mem_din;

    modport slave (
        input  in_byte,
        input  in_valid,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_din
    );

    modport master (
        output in_byte,
        output in_valid,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_din
    );
endinterface

// File: rtl/small_poly_unpack.sv
// -----------------------------------------------------------------------------
// small_poly_unpack
//
// Purpose : decodes a packed ternary polynomial (P = 677 coefficients, 2 bits
//           each, 4 per byte, 170 bytes) into the coefficient RAM, one 11-bit
//           coefficient per cycle. Counts the nonzero coefficients, flags
//           illegal codes, and compares the nonzero count with the fixed
//           weight W = 202.
//
//           Code c maps to value c-1: 00 -> -1 (11'h7FF), 01 -> 0,
//           10 -> +1 (11'h001), 11 -> illegal (written as 0, sets fmt_err).
//           The last byte carries only index 676 in bits[1:0]; any nonzero
//           bit in its bits[7:2] also sets fmt_err.
//
// Ports   :
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      one-cycle request to begin a run (ignored while busy)
//   bus        small_poly_unpack_if.slave (byte stream in, RAM write port out)
//   busy       high from the cycle after start is accepted through done
//   done       one-cycle completion pulse
//   nz_count   nonzero coefficients written in the current/last run
//   weight_ok  nz_count == W, valid at done and held until the next start
//   fmt_err    sticky per run: an illegal code was seen
//
// Configuration:
//   SMALL_UNPACK_WEIGHT_CHECK_EN
//     defined   : the CHECK state compares nz_count with W into weight_ok.
//     undefined : CHECK is still traversed (identical latency) but weight_ok
//                 stays 0. nz_count is maintained in both builds.
// -----------------------------------------------------------------------------
module small_poly_unpack (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    small_poly_unpack_if.slave         bus,
    output logic                       busy,
    output logic                       done,
    output logic [10:0]                nz_count,
    output logic                       weight_ok,
    output logic                       fmt_err
);

    localparam logic [10:0] P_COEFFS = 11'd677;
    localparam logic [10:0] LAST_IDX = 11'd676;
`ifdef SMALL_UNPACK_WEIGHT_CHECK_EN
    localparam logic [10:0] W_TARGET = 11'd202;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        CHECK = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t      state_reg,     state_next;
    logic [10:0] index_reg,     index_next;     // next coefficient index to issue
    logic [7:0]  byte_reg,      byte_next;      // byte currently being emitted
    logic [1:0]  slot_reg,      slot_next;      // slot shown on the RAM port now
    logic [1:0]  last_slot_reg, last_slot_next; // 3 for full bytes, 0 for the tail byte
    logic        mem_we_reg,    mem_we_next;
    logic [10:0] mem_addr_reg,  mem_addr_next;
    logic [10:0] mem_din_reg,   mem_din_next;
    logic [10:0] nz_reg,        nz_next;
    logic        fmt_err_reg,   fmt_err_next;
    logic        weight_ok_reg, weight_ok_next;

    // Split the held byte into its four 2-bit codes, slot 0 = bits[1:0].
    logic [1:0] slot_code [4];
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            assign slot_code[gi] = byte_reg[2*gi +: 2];
        end
    endgenerate

    function automatic logic [10:0] decode_code(input logic [1:0] code);
        logic [10:0] val;
        case (code)
            2'b00:   val = 11'h7FF;  // -1
            2'b10:   val = 11'h001;  // +1
            default: val = 11'h000;  // 0, and illegal 11 is written as 0
        endcase
        return val;
    endfunction

    logic [1:0] cur_code;
    logic [1:0] nxt_code;
    logic [1:0] slot_inc;

    assign slot_inc = slot_reg + 2'd1;
    assign cur_code = slot_code[slot_reg];
    assign nxt_code = slot_code[slot_inc];

    // -------------------------------------------------------------------------
    // Next-state / datapath logic.
    //
    // The RAM port is fully registered, so each coefficient is staged one
    // cycle ahead: accepting a byte in LOAD stages slot 0, and every WRITE
    // cycle that is not the last one stages the following slot. As a result
    // mem_we is high exactly during the WRITE cycles, with address and data
    // stable for the whole cycle. Counters and fmt_err are updated from the
    // slot that is on the port during that WRITE cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        index_next     = index_reg;
        byte_next      = byte_reg;
        slot_next      = slot_reg;
        last_slot_next = last_slot_reg;
        mem_we_next    = 1'b0;
        mem_addr_next  = mem_addr_reg;
        mem_din_next   = mem_din_reg;
        nz_next        = nz_reg;
        fmt_err_next   = fmt_err_reg;
        weight_ok_next = weight_ok_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    index_next     = 11'd0;
                    nz_next        = 11'd0;
                    fmt_err_next   = 1'b0;
                    weight_ok_next = 1'b0;
                    state_next     = LOAD;
                end
            end

            LOAD: begin
                if (bus.in_valid) begin
                    byte_next = bus.in_byte;
                    slot_next = 2'd0;
                    if (index_reg == LAST_IDX) begin
                        // Tail byte: only bits[1:0] carry a coefficient.
                        last_slot_next = 2'd0;
                        if (bus.in_byte[7:2] != 6'd0) begin
                            fmt_err_next = 1'b1;
                        end
                    end else begin
                        last_slot_next = 2'd3;
                    end
                    mem_we_next   = 1'b1;
                    mem_addr_next = index_reg;
                    mem_din_next  = decode_code(bus.in_byte[1:0]);
                    index_next    = index_reg + 11'd1;
                    state_next    = WRITE;
                end
            end

            WRITE: begin
                if (cur_code == 2'b11) begin
                    fmt_err_next = 1'b1;
                end
                // Codes 00 (-1) and 10 (+1) are the nonzero ones.
                if (cur_code[0] == 1'b0) begin
                    nz_next = nz_reg + 11'd1;
                end
                if (slot_reg != last_slot_reg) begin
                    slot_next     = slot_inc;
                    mem_we_next   = 1'b1;
                    mem_addr_next = index_reg;
                    mem_din_next  = decode_code(nxt_code);
                    index_next    = index_reg + 11'd1;
                end else if (index_reg < P_COEFFS) begin
                    state_next = LOAD;
                end else begin
                    state_next = CHECK;
                end
            end

            CHECK: begin
`ifdef SMALL_UNPACK_WEIGHT_CHECK_EN
                weight_ok_next = (nz_reg == W_TARGET);
`else
                weight_ok_next = 1'b0;
`endif
                state_next = FIN;
            end

            FIN: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            index_reg     <= 11'd0;
            byte_reg      <= 8'd0;
            slot_reg      <= 2'd0;
            last_slot_reg <= 2'd0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= 11'd0;
            mem_din_reg   <= 11'd0;
            nz_reg        <= 11'd0;
            fmt_err_reg   <= 1'b0;
            weight_ok_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            index_reg     <= index_next;
            byte_reg      <= byte_next;
            slot_reg      <= slot_next;
            last_slot_reg <= last_slot_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_din_reg   <= mem_din_next;
            nz_reg        <= nz_next;
            fmt_err_reg   <= fmt_err_next;
            weight_ok_reg <= weight_ok_next;
        end
    end

    // Handshake/status outputs are pure decodes of the state register.
    assign bus.in_ready = (state_reg == LOAD);
    assign busy         = (state_reg != IDLE);
    assign done         = (state_reg == FIN);

    assign bus.mem_we   = mem_we_reg;
    assign bus.mem_addr = mem_addr_reg;
    assign bus.mem_din  = mem_din_reg;
    assign nz_count     = nz_reg;
    assign fmt_err      = fmt_err_reg;
    assign weight_ok    = weight_ok_reg;

endmodule

// File: tb/tb_small_poly_unpack.sv
// -----------------------------------------------------------------------------
// tb_small_poly_unpack
//
// Drives packed byte streams into small_poly_unpack and checks every RAM
// write, the final counters and flags, the run latency, stall behaviour,
// ignored start pulses and mid-run reset against a reference model that
// derives each coefficient directly from the byte array (value = code - 1).
// -----------------------------------------------------------------------------
module tb_small_poly_unpack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [10:0] nz_count;
    logic        weight_ok;
    logic        fmt_err;

    small_poly_unpack_if bus ();

    small_poly_unpack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bus       (bus.slave),
        .busy      (busy),
        .done      (done),
        .nz_count  (nz_count),
        .weight_ok (weight_ok),
        .fmt_err   (fmt_err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  bytes_arr [170];
    logic [10:0] exp_mem   [677];
    int          exp_nz;
    bit          exp_fmt;
    bit          exp_wok;
    int          wr_ptr;
    bit          checking = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference: coefficient i is code (byte[i/4] >> 2*(i%4)) & 3, value code-1.
    task automatic build_model();
        exp_nz  = 0;
        exp_fmt = 1'b0;
        for (int i = 0; i < 677; i++) begin
            int code;
            int v;
            code = (int'(bytes_arr[i / 4]) >> (2 * (i % 4))) & 3;
            if (code == 3) begin
                exp_fmt = 1'b1;
                v = 0;
            end else begin
                v = code - 1;
            end
            if (v != 0) exp_nz++;
            exp_mem[i] = v[10:0];
        end
        if ((bytes_arr[169] >> 2) != 8'd0) exp_fmt = 1'b1;
`ifdef SMALL_UNPACK_WEIGHT_CHECK_EN
        exp_wok = (exp_nz == 202);
`else
        exp_wok = 1'b0;
`endif
    endtask

    task automatic fill_bytes(input logic [7:0] body, input logic [7:0] tail);
        for (int i = 0; i < 169; i++) bytes_arr[i] = body;
        bytes_arr[169] = tail;
    endtask

    // Every RAM write must hit the next ascending address with the model value,
    // and never coincide with a LOAD (stall) cycle.
    always @(negedge clk) begin
        if (checking && bus.mem_we) begin
            if (wr_ptr < 677) begin
                check("mem_addr", 32'(bus.mem_addr), 32'(wr_ptr));
                check("mem_din", 32'(bus.mem_din), 32'(exp_mem[wr_ptr]));
            end else begin
                check("extra_write", 32'(wr_ptr), 32'd676);
            end
            check("write_during_load", 32'(bus.in_ready), 32'd0);
            wr_ptr++;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 0);
        check({tag, "_mem_we"}, 32'(bus.mem_we), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_weight_ok"}, 32'(weight_ok), 0);
        check({tag, "_fmt_err"}, 32'(fmt_err), 0);
        check({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
        check({tag, "_mem_din"}, 32'(bus.mem_din), 0);
        check({tag, "_nz_count"}, 32'(nz_count), 0);
    endtask

    // One run: stall_pct = % of cycles with in_valid low, inject_start = random
    // start pulses while busy, abort_at > 0 = assert rst_n at that run cycle.
    task automatic run(input string name, input int stall_pct, input bit inject_start,
                       input bit check_lat, input int abort_at);
        int  ptr;
        int  cyc;
        bit  got_done;
        build_model();
        wr_ptr   = 0;
        checking = 1'b1;
        ptr      = 0;
        cyc      = 0;
        got_done = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, "_busy_after_start"}, 32'(busy), 1);
        check({name, "_in_ready_after_start"}, 32'(bus.in_ready), 1);
        while (cyc < 20000) begin
            cyc++;
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (abort_at > 0 && cyc == abort_at) begin
                checking     = 1'b0;
                bus.in_valid = 1'b0;
                start        = 1'b0;
                #2 rst_n = 1'b0;
                #1 check_reset_outputs({name, "_midrun_reset"});
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                check_reset_outputs({name, "_after_release"});
                $display("run %s: reset asserted at cycle %0d after %0d writes", name, cyc, wr_ptr);
                return;
            end
            start = (inject_start && $urandom_range(0, 19) == 0);
            if (ptr < 170 && $urandom_range(0, 99) >= stall_pct) begin
                bus.in_valid = 1'b1;
                bus.in_byte  = bytes_arr[ptr];
            end else begin
                bus.in_valid = 1'b0;
                bus.in_byte  = 8'($urandom);
            end
            if (bus.in_valid && bus.in_ready) ptr++;
            @(negedge clk);
        end
        start        = 1'b0;
        bus.in_valid = 1'b0;
        checking     = 1'b0;
        if (!got_done) begin
            check({name, "_done_timeout"}, 0, 1);
        end else begin
            if (check_lat) check({name, "_latency"}, 32'(cyc), 849);
            check({name, "_writes"}, 32'(wr_ptr), 677);
            check({name, "_nz_count"}, 32'(nz_count), 32'(exp_nz));
            check({name, "_fmt_err"}, 32'(fmt_err), 32'(exp_fmt));
            check({name, "_weight_ok"}, 32'(weight_ok), 32'(exp_wok));
            @(negedge clk);
            check({name, "_done_pulse"}, 32'(done), 0);
            check({name, "_busy_idle"}, 32'(busy), 0);
            check({name, "_weight_ok_hold"}, 32'(weight_ok), 32'(exp_wok));
        end
        $display("run %s: cycles=%0d writes=%0d nz=%0d fmt_err=%0d weight_ok=%0d",
                 name, cyc, wr_ptr, nz_count, fmt_err, weight_ok);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // All zero coefficients.
        fill_bytes(8'h55, 8'h55 & 8'h03 | 8'h01);
        build_model();
        check("model_nz_zero", 32'(exp_nz), 0);
        run("all_zero", 0, 1'b0, 1'b1, 0);

        // +1 at even indices, 0 at odd.
        fill_bytes(8'h66, 8'h02);
        build_model();
        check("model_nz_alt", 32'(exp_nz), 339);
        check("model_alt_676", 32'(exp_mem[676]), 32'h001);
        run("alternating", 0, 1'b0, 1'b1, 0);

        // Exactly 202 nonzero coefficients, all -1.
        fill_bytes(8'h55, 8'h01);
        for (int i = 0; i < 50; i++) bytes_arr[i] = 8'h00;
        bytes_arr[50] = 8'h50;
        build_model();
        check("model_nz_weight", 32'(exp_nz), 202);
        check("model_neg_one", 32'(exp_mem[0]), 32'h7FF);
        run("weight_202", 0, 1'b0, 1'b1, 0);

        // Illegal byte in the body.
        fill_bytes(8'h55, 8'h01);
        bytes_arr[10] = 8'hFF;
        build_model();
        check("model_ff_41", 32'(exp_mem[41]), 0);
        check("model_ff_fmt", 32'(exp_fmt), 1);
        run("illegal_body", 0, 1'b0, 1'b1, 0);

        // Illegal upper bits in the tail byte.
        fill_bytes(8'h55, 8'h05);
        run("illegal_tail", 0, 1'b0, 1'b1, 0);

        // Random legal codes, 50% input stalls, stray start pulses.
        for (int i = 0; i < 170; i++) begin
            logic [7:0] b;
            for (int s = 0; s < 4; s++) b[2*s +: 2] = 2'($urandom_range(0, 2));
            bytes_arr[i] = b;
        end
        bytes_arr[169] = {6'd0, bytes_arr[169][1:0]};
        run("random_stall", 50, 1'b1, 1'b0, 0);

        // Same image without stalls must produce the same writes and latency.
        run("random_nostall", 0, 1'b0, 1'b1, 0);

        // Random image with illegal codes, abandoned by reset, then rerun.
        for (int i = 0; i < 170; i++) bytes_arr[i] = 8'($urandom);
        run("abort", 0, 1'b0, 1'b0, 300);
        run("after_abort", 20, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
